// File: rtl/stack_arb_pkg.sv
// Shared FSM state and operation encodings for the stack arbiter.
package stack_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        RDWAIT = 2'd2,
        RESP   = 2'd3
    } state_e;

    localparam logic OP_PUSH = 1'b1;
    localparam logic OP_POP  = 1'b0;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; a tie goes to the requester not granted last.
module rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    input  logic       update_i,
    output logic [1:0] grant_o
);

    logic last_b_q;  // 1: B held the most recent grant

    always_comb begin
        grant_o = req_i;
        if (req_i == 2'b11) begin
            grant_o = last_b_q ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_b_q <= 1'b1;
        end else if (update_i && (grant_o != 2'b00)) begin
            last_b_q <= grant_o[1];
        end
    end

endmodule

// File: rtl/stack_arbiter.sv
// Arbitrates two requesters onto a 1-bit stack. Define STACK_ARB_ERRCNT_EN to
// add a saturating 8-bit count of rejected transactions on port err_cnt.
module stack_arbiter
    import stack_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    input  logic                         req_a,
    input  logic                         req_b,
    input  logic                         op_a,
    input  logic                         op_b,
    input  logic                         wdata_a,
    input  logic                         wdata_b,
    output logic                         ack_a,
    output logic                         ack_b,
    output logic                         rdata,
    output logic                         err,
    output logic                         st_push,
    output logic                         st_pop,
    output logic                         st_data,
    input  logic                         st_dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
`ifdef STACK_ARB_ERRCNT_EN
    ,
    output logic [7:0]                   err_cnt
`endif
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    state_e     state_q;
    logic [1:0] gnt_q;
    logic       op_q;
    logic       wd_q;
    logic       rbit_q;
    logic       err_pend_q;
    logic [1:0] arb_req;
    logic [1:0] arb_gnt;
    logic       arb_upd;

    // Outside IDLE the arbiter sees only the held grant, so the update in RESP
    // records the requester actually served, whatever req does meanwhile.
    assign arb_req = (state_q == IDLE) ? {req_b, req_a} : gnt_q;
    assign arb_upd = (state_q == RESP);

    rr_arb2 u_rr_arb2 (
        .clk_i    (CLK),
        .rst_ni   (RST_N),
        .req_i    (arb_req),
        .update_i (arb_upd),
        .grant_o  (arb_gnt)
    );

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            gnt_q      <= 2'b00;
            op_q       <= 1'b0;
            wd_q       <= 1'b0;
            rbit_q     <= 1'b0;
            err_pend_q <= 1'b0;
            count      <= '0;
            ack_a      <= 1'b0;
            ack_b      <= 1'b0;
            rdata      <= 1'b0;
            err        <= 1'b0;
            st_push    <= 1'b0;
            st_pop     <= 1'b0;
            st_data    <= 1'b0;
`ifdef STACK_ARB_ERRCNT_EN
            err_cnt    <= 8'd0;
`endif
        end else begin
            ack_a   <= 1'b0;
            ack_b   <= 1'b0;
            rdata   <= 1'b0;
            err     <= 1'b0;
            st_push <= 1'b0;
            st_pop  <= 1'b0;
            st_data <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (arb_gnt != 2'b00) begin
                        gnt_q      <= arb_gnt;
                        op_q       <= arb_gnt[0] ? op_a : op_b;
                        wd_q       <= arb_gnt[0] ? wdata_a : wdata_b;
                        rbit_q     <= 1'b0;
                        err_pend_q <= 1'b0;
                        state_q    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (op_q == OP_PUSH) begin
                        if (full) begin
                            err_pend_q <= 1'b1;
                        end else begin
                            st_push <= 1'b1;
                            st_data <= wd_q;
                            count   <= count + CW'(1);
                        end
                        state_q <= RESP;
                    end else if (empty) begin
                        err_pend_q <= 1'b1;
                        state_q    <= RESP;
                    end else begin
                        st_pop  <= 1'b1;
                        count   <= count - CW'(1);
                        state_q <= RDWAIT;
                    end
                end
                RDWAIT: begin
                    // Stack pops on this edge; its output still shows the old top.
                    rbit_q  <= st_dout;
                    state_q <= RESP;
                end
                RESP: begin
                    ack_a   <= gnt_q[0];
                    ack_b   <= gnt_q[1];
                    err     <= err_pend_q;
                    rdata   <= rbit_q;
                    state_q <= IDLE;
`ifdef STACK_ARB_ERRCNT_EN
                    if (err_pend_q && (err_cnt != 8'hFF)) begin
                        err_cnt <= err_cnt + 8'd1;
                    end
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/stack_arbiter.md
STACK_ARBITER -- requirements
Module: stack_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 8, the capacity of the attached 1-bit stack in entries.
REQ-002 SHALL have port CLK, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port RST_N, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have ports req_a and req_b, input, 1 each, requester A/B transaction request.
REQ-005 SHALL have ports op_a and op_b, input, 1 each, operation select; 1 = push, 0 = pop.
REQ-006 SHALL have ports wdata_a and wdata_b, input, 1 each, push data.
REQ-007 SHALL have ports ack_a and ack_b, output, 1 each, one-cycle completion pulse.
REQ-008 SHALL have ports rdata, output, 1, popped bit; and err, output, 1, rejected-transaction flag; both valid only while an ack is high.
REQ-009 SHALL have ports st_push, st_pop, st_data, output, 1 each, drive to the stack's push/pop/data inputs.
REQ-010 SHALL have port st_dout, input, 1, the stack's data output.
REQ-011 SHALL have ports full and empty, output, 1 each, occupancy flags.
REQ-012 SHALL have port count, output, $clog2(DEPTH+1), current occupancy.

Function
REQ-013 SHALL implement FSM states IDLE, ISSUE, RDWAIT, RESP.
REQ-014 IDLE: on any req high, SHALL grant one requester and latch its op and wdata, then go to ISSUE; otherwise stay in IDLE.
REQ-015 With both req high in IDLE, SHALL grant the requester not granted last; after reset the last grant is B, so A wins the first tie.
REQ-016 ISSUE: for a legal push, SHALL assert st_push for exactly one cycle with st_data = latched bit, increment count, and go to RESP.
REQ-017 ISSUE: for a legal pop, SHALL assert st_pop for exactly one cycle, decrement count, and go to RDWAIT.
REQ-018 A push with full=1 or a pop with empty=1 SHALL be illegal: no st_push/st_pop, count unchanged, err=1 in RESP.
REQ-019 RDWAIT: SHALL capture st_dout into rdata, then go to RESP.
REQ-020 RESP: SHALL pulse only the granted requester's ack for one cycle, update the last-grant pointer, and return to IDLE.
REQ-021 Latency from the IDLE sampling edge to ack high SHALL be 2 cycles for push or error, and 3 cycles for pop.
REQ-022 Requesters SHALL hold req, op and wdata until ack; a req dropped mid-transaction SHALL NOT abort it.
REQ-023 st_push and st_pop SHALL never be high together; at most one stack op per transaction.
REQ-024 full = (count == DEPTH) and empty = (count == 0), combinational from count; count SHALL never wrap.
REQ-025 rdata and err SHALL be 0 whenever no ack is high.

Reset
REQ-026 RST_N low SHALL immediately force state IDLE, count 0, empty 1, last grant B, and all other outputs 0, including mid-transaction; the pending transaction is lost and receives no ack.
REQ-027 Stack contents are not cleared by reset; after reset the arbiter SHALL treat the stack as empty.

Configuration
REQ-028 With STACK_ARB_ERRCNT_EN defined, SHALL add an 8-bit output err_cnt, reset to 0, incremented on each err ack and saturating at 255.
REQ-029 Without STACK_ARB_ERRCNT_EN, SHALL have no err_cnt port and no counter logic; all other behaviour identical.

Structure
REQ-030 SHALL take the FSM state enum and the OP_PUSH/OP_POP encodings from shared package stack_arb_pkg.
REQ-031 SHALL implement the two-way round-robin pointer as sub-module rr_arb2 (inputs: req pair, update strobe; output: grant pair).

Verification (DEPTH=8)
REQ-032 Reset, then A pushes 1 -> st_push pulses once with st_data=1, ack_a 2 cycles after sampling, err=0, count=1.
REQ-033 Push 0,1,1 then pop three times via B -> rdata sequence 1,1,0, each ack_b 3 cycles after sampling, count=0, empty=1.
REQ-034 req_a and req_b asserted together on an empty stack, both push -> A granted first, then B; count=2.
REQ-035 Pop on empty -> ack with err=1, no st_pop pulse; 9th push after 8 -> err=1, count stays 8, full=1; err_cnt=2 when STACK_ARB_ERRCNT_EN is defined.
REQ-036 RST_N low during RDWAIT -> outputs 0 at once, no ack, count=0; a new push after release completes normally.
